mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req_valid[i]  input  1 each, for i=0 (CPU load/store) and i=1 (loader/debug): request present.
REQ-006 SHALL have ports req_ready[i]  output  1 each: request accepted this cycle.
REQ-007 SHALL have ports req_we[i]  input  1 each; req_func3[i]  input  3 each; req_addr[i]  input  ADDR_WIDTH each; req_wdata[i]  input  DATA_WIDTH each.
REQ-008 SHALL have ports rsp_valid[i]  output  1 each; rsp_rdata  output  DATA_WIDTH, shared; rsp_err  output  1, shared.
REQ-009 SHALL have memory-side outputs mem_we 1, mem_func3 3, mem_addr ADDR_WIDTH and mem_wdata DATA_WIDTH, plus input mem_rdata DATA_WIDTH, which is combinational read data.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS and RESP; reset state SHALL be IDLE.
REQ-011 SHALL assert req_ready[i] only in IDLE and only for the granted requester; a handshake is req_valid & req_ready in the same cycle.
REQ-012 SHALL grant in IDLE by round-robin: sole valid requester wins; if both are valid, the requester not granted last wins; last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-013 SHALL register we, func3, addr, wdata and grant index on handshake, then move IDLE->ACCESS.
REQ-014 SHALL drive mem_* from registered request only in ACCESS; mem_we SHALL be high for exactly that one cycle on writes, otherwise 0; mem_addr, mem_func3 and mem_wdata SHALL be 0 outside ACCESS.
REQ-015 SHALL capture mem_rdata into rsp_rdata at the end of ACCESS for reads; for writes, rsp_rdata SHALL be 0; then move ACCESS->RESP.
REQ-016 SHALL assert rsp_valid[grant] for exactly one cycle in RESP, then return to IDLE unconditionally; with no stall, the response arrives 2 cycles after the handshake.
REQ-017 SHALL hold rsp_rdata and rsp_err stable from RESP until the next RESP.
REQ-018 SHALL sustain at most one access per 3 cycles; a requester deasserting valid before handshake SHALL simply lose the grant, with no side effects.
REQ-019 SHALL pass func3 unmodified: 0 SB/LB, 1 SH/LH, 2 SW/LW, 4 LBU, 5 LHU.

Reset
REQ-020 SHALL, on rst assertion in any state, immediately force: state IDLE, req_ready 0, rsp_valid 0, mem_we 0, all mem_* 0, rsp_rdata 0, rsp_err 0, last-grant pointer 1.
REQ-021 SHALL abort an in-flight access on reset mid-ACCESS or mid-RESP; no response is issued for it.

Configuration
REQ-022 SHALL support macro MEM_ARB_ALIGN_CHECK_EN.
REQ-023 With MEM_ARB_ALIGN_CHECK_EN defined, a request with func3 in {1,5} and addr[0]=1, or with func3=2 and addr[1:0]!=0, SHALL skip ACCESS: IDLE->RESP directly, mem_we stays 0, rsp_rdata=0, rsp_err=1. Latency is 1 cycle.
REQ-024 Without the macro, rsp_err SHALL be tied 0 and all requests SHALL go through ACCESS.

Structure
REQ-025 SHALL place the FSM state enum and func3 constants (FUNC3_B, FUNC3_H, FUNC3_W, FUNC3_BU, FUNC3_HU) in shared package mem_pkg.
REQ-026 SHALL implement grant selection as sub-module rr_arbiter2: 2 requests in, one-hot grant out, plus an update strobe.

Verification
REQ-027 Bench SHALL check single write: req0 SW addr 0x10, wdata 0xDEADBEEF -> mem_we=1 for 1 cycle with mem_addr 0x10; rsp_valid[0] 2 cycles after handshake.
REQ-028 Bench SHALL check read-back: req0 LW 0x10 with mem_rdata=0xDEADBEEF -> rsp_rdata=0xDEADBEEF, rsp_valid[0] only.
REQ-029 Bench SHALL check tie: both valid from reset -> grant order 0,1,0,1; no starvation over 8 requests.
REQ-030 Bench SHALL check reset mid-ACCESS: rst during a write's ACCESS -> mem_we=0 immediately, no rsp_valid, next request served normally.
REQ-031 Bench SHALL check, with MEM_ARB_ALIGN_CHECK_EN, misaligned LW 0x12 -> rsp_err=1, rsp_valid 1 cycle after handshake, mem_we never asserted; without the macro, the same access is forwarded and rsp_err=0.
REQ-032 Bench SHALL check LBU 0x3 on req1 while req0 is idle -> mem_func3=4, mem_addr=0x3, rsp_valid[1].

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states, RISC-V load/store
// func3 encodings and the alignment predicate used when MEM_ARB_ALIGN_CHECK_EN is defined.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] FUNC3_B  = 3'd0;
  localparam logic [2:0] FUNC3_H  = 3'd1;
  localparam logic [2:0] FUNC3_W  = 3'd2;
  localparam logic [2:0] FUNC3_BU = 3'd4;
  localparam logic [2:0] FUNC3_HU = 3'd5;

  // Halfwords need an even address, words a 4-byte aligned one; bytes are always fine.
  function automatic logic misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
    case (func3)
      FUNC3_B, FUNC3_BU: return 1'b0;
      FUNC3_H, FUNC3_HU: return addr_lo[0];
      FUNC3_W:           return addr_lo != 2'b00;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a sole requester wins, a tie goes to the requester
// not granted last. The last-grant pointer moves only on the update strobe.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = '0;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
    else              grant = req;
  end

  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last <= 1'b1;
    else if (update) last <= grant[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: IDLE grants/captures, ACCESS drives memory for one cycle,
// RESP returns the response. Optional alignment check via MEM_ARB_ALIGN_CHECK_EN.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [5:0]              req_func3,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_we,
  output logic [2:0]              mem_func3,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  state_t state, state_nxt;

  logic [1:0]            grant;
  logic                  hs;
  logic                  sel;
  logic                  sel_we;
  logic [2:0]            sel_func3;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  bad;

  logic                  r_we;
  logic [2:0]            r_func3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_gidx;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .update (hs),
    .grant  (grant)
  );

  assign req_ready = (state == IDLE && !rst) ? grant : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign sel       = grant[1];

  always_comb begin
    sel_we    = sel ? req_we[1]                          : req_we[0];
    sel_func3 = sel ? req_func3[5:3]                     : req_func3[2:0];
    sel_addr  = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    sel_wdata = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  end

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign bad = misaligned(sel_func3, sel_addr[1:0]);
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = bad ? RESP : ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      r_we    <= 1'b0;
      r_func3 <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_gidx  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        r_we    <= sel_we;
        r_func3 <= sel_func3;
        r_addr  <= sel_addr;
        r_wdata <= sel_wdata;
        r_gidx  <= sel;
      end
    end
  end

  // Response data is held between responses; only ACCESS or a rejected request rewrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            rsp_rdata <= '0;
    else if (state == ACCESS)           rsp_rdata <= r_we ? '0 : mem_rdata;
    else if (state == IDLE && hs && bad) rsp_rdata <= '0;
  end

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_err <= 1'b0;
    else if (state == ACCESS)           r_err <= 1'b0;
    else if (state == IDLE && hs && bad) r_err <= 1'b1;
  end
  assign rsp_err = r_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign mem_we    = (state == ACCESS) && r_we;
  assign mem_func3 = (state == ACCESS) ? r_func3 : '0;
  assign mem_addr  = (state == ACCESS) ? r_addr  : '0;
  assign mem_wdata = (state == ACCESS) ? r_wdata : '0;
  assign rsp_valid = (state == RESP) ? {r_gidx, ~r_gidx} : 2'b00;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations for the alignment test
// follow whether MEM_ARB_ALIGN_CHECK_EN is defined for the build.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_we;
  logic [5:0]    req_func3;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_we;
  logic [2:0]    mem_func3;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int tests = 0;
  int fails = 0;
  int cnt0  = 0;
  int cnt1  = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_we    (mem_we),
    .mem_func3 (mem_func3),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [2:0] f3,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i]          = we;
    req_func3[i*3 +: 3] = f3;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_func3 = '0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0;
    repeat (2) tick();

    // Reset state, with a write already waiting on requester 0
    set_req(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    req_valid = 2'b01;
    #1;
    chk("rst_ready",  req_ready, 2'b00);
    chk("rst_rspv",   rsp_valid, 2'b00);
    chk("rst_memwe",  mem_we,    1'b0);
    chk("rst_maddr",  mem_addr,  32'h0);
    chk("rst_rdata",  rsp_rdata, 32'h0);
    chk("rst_err",    rsp_err,   1'b0);

    // Single write SW 0x10
    rst = 1'b0;
    #1;
    chk("wr_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("wr_memwe",  mem_we,    1'b1);
    chk("wr_maddr",  mem_addr,  32'h10);
    chk("wr_mwdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_mf3",    mem_func3, 3'd2);
    chk("wr_acc_rspv", rsp_valid, 2'b00);
    chk("wr_acc_ready", req_ready, 2'b00);
    tick();
    chk("wr_rspv",     rsp_valid, 2'b01);
    chk("wr_memwe_off", mem_we,   1'b0);
    chk("wr_maddr_off", mem_addr, 32'h0);
    chk("wr_rdata",    rsp_rdata, 32'h0);
    tick();
    chk("wr_rspv_off", rsp_valid, 2'b00);

    // Read-back LW 0x10
    set_req(0, 1'b0, 3'd2, 32'h10, 32'h0);
    req_valid = 2'b01;
    mem_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("rd_memwe", mem_we,   1'b0);
    chk("rd_maddr", mem_addr, 32'h10);
    tick();
    mem_rdata = 32'h0BADF00D;
    chk("rd_rspv",  rsp_valid, 2'b01);
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_err",   rsp_err,   1'b0);
    tick();
    chk("rd_hold",  rsp_rdata, 32'hDEADBEEF);

    // LBU 0x3 on requester 1 alone
    set_req(1, 1'b0, 3'd4, 32'h3, 32'h0);
    req_valid = 2'b10;
    mem_rdata = 32'hA5;
    #1;
    chk("lbu_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("lbu_mf3",   mem_func3, 3'd4);
    chk("lbu_maddr", mem_addr,  32'h3);
    tick();
    chk("lbu_rspv",  rsp_valid, 2'b10);
    chk("lbu_rdata", rsp_rdata, 32'hA5);
    tick();

    // Tie from reset: grants must alternate starting with requester 0
    rst = 1'b1;
    set_req(0, 1'b0, 3'd2, 32'h100, 32'h0);
    set_req(1, 1'b0, 3'd2, 32'h200, 32'h0);
    req_valid = 2'b11;
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] exp_g;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      mem_rdata = 32'h1000 + k;
      chk("tie_ready", req_ready, exp_g);
      tick();
      chk("tie_maddr", mem_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
      chk("tie_busy",  req_ready, 2'b00);
      tick();
      chk("tie_rspv",  rsp_valid, exp_g);
      chk("tie_rdata", rsp_rdata, 32'h1000 + k);
      cnt0 += int'(rsp_valid[0]);
      cnt1 += int'(rsp_valid[1]);
      tick();
    end
    req_valid = 2'b00;
    chk("tie_count", {cnt0[15:0], cnt1[15:0]}, {16'd4, 16'd4});

    // Reset during a write's ACCESS
    set_req(0, 1'b1, 3'd2, 32'h20, 32'h12345678);
    req_valid = 2'b01;
    #1;
    chk("ra_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("ra_memwe", mem_we, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("ra_memwe_rst", mem_we,    1'b0);
    chk("ra_maddr_rst", mem_addr,  32'h0);
    chk("ra_rspv_rst",  rsp_valid, 2'b00);
    tick();
    chk("ra_rspv_hold", rsp_valid, 2'b00);
    rst = 1'b0;
    tick();
    chk("ra_rspv_a", rsp_valid, 2'b00);
    tick();
    chk("ra_rspv_b", rsp_valid, 2'b00);
    set_req(1, 1'b0, 3'd2, 32'h40, 32'h0);
    req_valid = 2'b10;
    mem_rdata = 32'h55AA;
    #1;
    chk("ra_next_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("ra_next_maddr", mem_addr, 32'h40);
    tick();
    chk("ra_next_rspv",  rsp_valid, 2'b10);
    chk("ra_next_rdata", rsp_rdata, 32'h55AA);
    tick();

    // Misaligned LW 0x12
    set_req(0, 1'b0, 3'd2, 32'h12, 32'h0);
    req_valid = 2'b01;
    mem_rdata = 32'hCAFEF00D;
    #1;
    chk("mis_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    chk("mis_rspv",  rsp_valid, 2'b01);
    chk("mis_err",   rsp_err,   1'b1);
    chk("mis_rdata", rsp_rdata, 32'h0);
    chk("mis_memwe", mem_we,    1'b0);
    chk("mis_maddr", mem_addr,  32'h0);
    tick();
    chk("mis_rspv_off", rsp_valid, 2'b00);
    chk("mis_err_hold", rsp_err,   1'b1);
`else
    chk("mis_maddr", mem_addr,  32'h12);
    chk("mis_memwe", mem_we,    1'b0);
    chk("mis_acc_rspv", rsp_valid, 2'b00);
    tick();
    chk("mis_rspv",  rsp_valid, 2'b01);
    chk("mis_err",   rsp_err,   1'b0);
    chk("mis_rdata", rsp_rdata, 32'hCAFEF00D);
`endif
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
